// File: rtl/rtc_timekeeper.sv
// rtc_timekeeper: 24-hour timekeeper with an integrated 1 Hz prescaler.
//
// The prescaler counts clk cycles while run=1. On the edge where it wraps from
// TICKS_PER_SEC-1 to 0, the time advances by one second. sec_tick and the
// carry pulses are registered, so they appear in the cycle after that edge,
// alongside the updated time.
//
// Optional feature macro: RTC_ALARM_EN (adds alarm_arm/alarm_min/alarm_hr
// inputs and the alarm output).
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high; clears all state
//   run        1 = time advances, 0 = prescaler and time frozen
//   load       single-cycle strobe: set time from load_hr/load_min/load_sec
//   load_sec   seconds to load (0-59)
//   load_min   minutes to load (0-59)
//   load_hr    hours to load (0-23)
//   alarm_arm  (RTC_ALARM_EN) enables the alarm comparison
//   alarm_min  (RTC_ALARM_EN) alarm minutes
//   alarm_hr   (RTC_ALARM_EN) alarm hours
//   mode_12h   selects the 12-hour view on disp_hours/pm
//   seconds    current seconds
//   minutes    current minutes
//   hours      current hours, 24-hour format
//   disp_hours display hours (0-23, or 1-12 in 12-hour view)
//   pm         PM flag in 12-hour view, 0 otherwise
//   sec_tick   1-cycle pulse on each second advance
//   min_carry  1-cycle pulse when seconds wrap 59->0
//   hr_carry   1-cycle pulse when minutes wrap 59->0
//   day_carry  1-cycle pulse on 23:59:59 -> 00:00:00
//   load_err   1-cycle pulse when a load is rejected
//   alarm      (RTC_ALARM_EN) 1-cycle pulse when a tick reaches alarm_hr:alarm_min:00

module rtc_timekeeper #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int PRESC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       load,
  input  logic [5:0] load_sec,
  input  logic [5:0] load_min,
  input  logic [4:0] load_hr,
`ifdef RTC_ALARM_EN
  input  logic       alarm_arm,
  input  logic [5:0] alarm_min,
  input  logic [4:0] alarm_hr,
  output logic       alarm,
`endif
  input  logic       mode_12h,
  output logic [5:0] seconds,
  output logic [5:0] minutes,
  output logic [4:0] hours,
  output logic [4:0] disp_hours,
  output logic       pm,
  output logic       sec_tick,
  output logic       min_carry,
  output logic       hr_carry,
  output logic       day_carry,
  output logic       load_err
);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);

  logic [PRESC_W-1:0] presc;
  logic               load_in_range;
  logic               load_ok;
  logic               terminal;
  logic               sec_wrap;
  logic               min_wrap;
  logic               hr_wrap;
  logic [5:0]         sec_nxt;
  logic [5:0]         min_nxt;
  logic [4:0]         hr_nxt;

  assign load_in_range = (load_sec < 6'd60) && (min_ok_check(load_min)) && (load_hr < 5'd24);
  assign load_ok       = load && load_in_range;
  // Terminal count only matters while running; with run=0 everything holds.
  assign terminal      = run && (presc == PRESC_LAST);

  function automatic logic min_ok_check(input logic [5:0] m);
    return m < 6'd60;
  endfunction

  assign sec_wrap = (seconds == 6'd59);
  assign min_wrap = (minutes == 6'd59);
  assign hr_wrap  = (hours == 5'd23);

  // Time value after a one-second advance.
  always_comb begin
    sec_nxt = sec_wrap ? 6'd0 : seconds + 6'd1;
    min_nxt = minutes;
    hr_nxt  = hours;
    if (sec_wrap) begin
      min_nxt = min_wrap ? 6'd0 : minutes + 6'd1;
      if (min_wrap) begin
        hr_nxt = hr_wrap ? 5'd0 : hours + 5'd1;
      end
    end
  end

`ifdef RTC_ALARM_EN
  // The advanced time is always in range, so out-of-range alarm settings
  // can never compare equal.
  logic alarm_hit;
  assign alarm_hit = alarm_arm && sec_wrap && (min_nxt == alarm_min) && (hr_nxt == alarm_hr);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc     <= '0;
      seconds   <= '0;
      minutes   <= '0;
      hours     <= '0;
      sec_tick  <= 1'b0;
      min_carry <= 1'b0;
      hr_carry  <= 1'b0;
      day_carry <= 1'b0;
      load_err  <= 1'b0;
`ifdef RTC_ALARM_EN
      alarm     <= 1'b0;
`endif
    end else begin
      sec_tick  <= 1'b0;
      min_carry <= 1'b0;
      hr_carry  <= 1'b0;
      day_carry <= 1'b0;
      load_err  <= load && !load_in_range;
`ifdef RTC_ALARM_EN
      alarm     <= 1'b0;
`endif
      if (load_ok) begin
        // A valid load wins over a coinciding terminal count; that tick is dropped.
        seconds <= load_sec;
        minutes <= load_min;
        hours   <= load_hr;
        presc   <= '0;
      end else if (terminal) begin
        presc     <= '0;
        seconds   <= sec_nxt;
        minutes   <= min_nxt;
        hours     <= hr_nxt;
        sec_tick  <= 1'b1;
        min_carry <= sec_wrap;
        hr_carry  <= sec_wrap && min_wrap;
        day_carry <= sec_wrap && min_wrap && hr_wrap;
`ifdef RTC_ALARM_EN
        alarm     <= alarm_hit;
`endif
      end else if (run) begin
        presc <= presc + PRESC_W'(1);
      end
    end
  end

  // 12-hour view: purely combinational from hours.
  always_comb begin
    disp_hours = hours;
    pm         = 1'b0;
    if (mode_12h) begin
      if (hours == 5'd0) begin
        disp_hours = 5'd12;
      end else if (hours < 5'd12) begin
        disp_hours = hours;
      end else if (hours == 5'd12) begin
        disp_hours = 5'd12;
        pm         = 1'b1;
      end else begin
        disp_hours = hours - 5'd12;
        pm         = 1'b1;
      end
    end
  end

endmodule

// File: doc/rtc_timekeeper.md
Name: rtc_timekeeper

Overview:
Parametrised 24-hour timekeeper that generalises the team's seconds-only clock counter.
- Integrated prescaler derives 1 Hz from the system clock; full seconds/minutes/hours rollover chain with carry pulses.
- Synchronous time-load port with range checking; run/stop control; 12/24-hour display view.
- Sits between the board clock and display/alarm logic.

Parameters:
TICKS_PER_SEC, 50000000, clk cycles per second; legal range >= 1.
PRESC_W, $clog2(TICKS_PER_SEC) (minimum 1), prescaler counter width; derived, do not override.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high; clears all state.
run  in  1  1 = time advances; 0 = prescaler and time frozen.
load  in  1  single-cycle strobe: set time from load_* inputs.
load_sec  in  6  seconds to load, 0-59.
load_min  in  6  minutes to load, 0-59.
load_hr  in  5  hours to load, 0-23.
mode_12h  in  1  selects the 12-hour view on disp_hours/pm.
seconds  out  6  current seconds, 0-59.
minutes  out  6  current minutes, 0-59.
hours  out  5  current hours, 24-hour format, 0-23.
disp_hours  out  5  display hours: 0-23 when mode_12h=0; 1-12 when mode_12h=1.
pm  out  1  PM flag when mode_12h=1; 0 when mode_12h=0.
sec_tick  out  1  1-cycle pulse on each second advance.
min_carry  out  1  1-cycle pulse when seconds wrap 59->0.
hr_carry  out  1  1-cycle pulse when minutes wrap 59->0 (coincident with min_carry).
day_carry  out  1  1-cycle pulse when 23:59:59 -> 00:00:00.
load_err  out  1  1-cycle pulse when a load is rejected.

Behaviour:
- Reset (async): prescaler=0, seconds=minutes=hours=0, all pulse outputs=0.
- Prescaler: increments while run=1. At TICKS_PER_SEC-1 it wraps to 0, and on that same edge the time advances by 1 s.
- sec_tick and carry pulses are registered and high for exactly the cycle following that edge, aligned with the updated time values.
- TICKS_PER_SEC=1: time advances on every cycle while run=1, and sec_tick stays high continuously.
- run=0: prescaler holds its value (not cleared) and no pulses are generated. Resuming continues the partial second.
- Rollover: seconds 59->0 increments minutes; minutes 59->0 increments hours; hours 23->0.
  - min_carry is asserted when seconds wrap.
  - hr_carry is asserted when seconds and minutes both wrap.
  - day_carry is asserted on a full wrap; all carries are asserted together at midnight.
- Load: load=1 with all three fields in range -> on the next edge the time registers take load_* values and the prescaler clears to 0. No sec_tick or carry pulses are generated for a load.
- Invalid load (any field out of range): time and prescaler are unchanged; load_err=1 for one cycle.
- Load takes priority over a coinciding prescaler terminal count; that tick is discarded. Load is accepted regardless of run.
- 12-hour view: combinational from hours, zero latency.
  - 0 -> 12, pm=0.
  - 1-11 -> same value, pm=0.
  - 12 -> 12, pm=1.
  - 13-23 -> hours-12, pm=1.
- Reset asserted mid-second discards partial-second progress. A pulse in flight is cleared immediately.

Optional Feature:
RTC_ALARM_EN defined:
- Adds inputs alarm_arm (1), alarm_min (6), alarm_hr (5) and output alarm (1).
- alarm pulses for 1 cycle, aligned with sec_tick, when a tick advance lands on alarm_hr:alarm_min:00 and alarm_arm=1.
- A load onto the matching time does not fire the alarm.
- Out-of-range alarm settings never match.
- Reset clears alarm.

RTC_ALARM_EN undefined: these ports and their logic are absent. All other behaviour is identical.

Test Plan:
- TICKS_PER_SEC=4, release reset, run=1 -> sec_tick every 4th cycle; seconds 0,1,2... Check that run=0 for 3 cycles mid-second delays the next tick by exactly 3 cycles.
- Load 23:59:58, run -> after 2 ticks time=00:00:00; sec_tick, min_carry, hr_carry and day_carry all high in the same single cycle.
- Load 10:60:00 -> load_err pulses once; time unchanged. Load issued on the prescaler terminal cycle -> loaded value is held and the prescaler restarts at 0.
- mode_12h=1, load hours 0, 11, 12, 13, 23 -> disp_hours/pm = 12/0, 11/0, 12/1, 1/1, 11/1. mode_12h=0 -> disp_hours=hours, pm=0.
- Assert reset asynchronously mid-second at 05:07:33 -> outputs read 0 before the next clk edge; the first tick comes 4 cycles after release.
- RTC_ALARM_EN: alarm 06:30, armed; load 06:29:59, run -> alarm pulses with the tick that reaches 06:30:00. Disarmed -> no pulse. Load 06:30:00 -> no pulse.
